minibus_arbiter: RTL

Two-master, one-slave arbiter placed in front of the on-chip RAM minibus slave. Requester 0 is the instruction-fetch port and requester 1 is the load/store port. The arbiter grants the shared slave round-robin and holds the grant until the slave responds. After every completed access it forces a one-cycle idle bubble on the slave side, because the RAM slave only re-arms its ready flag after `wen`/`ren` have been low for a cycle. A watchdog errors out accesses that never complete.

---
 rtl/minibus_pkg.sv | 36 +++
 rtl/rv32ima_pkg.sv | 12 +
 rtl/minibus_watchdog.sv | 40 ++++
 rtl/minibus_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/minibus_pkg.sv
// Minibus request/response types shared by masters, slaves and the arbiter.
package minibus_pkg;

  import rv32ima_pkg::*;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef struct packed {
    logic [BIT_WIDTH-1:0] addr;
    logic [BIT_WIDTH-1:0] wdata;
    logic                 wen;
    logic                 ren;
    logic [1:0]           width;
  } minibus_req_t;

  typedef struct packed {
    logic                 ack;
    logic                 err;
    logic [BIT_WIDTH-1:0] rdata;
  } minibus_res_t;

  function automatic logic is_active(input minibus_req_t r);
    return r.wen | r.ren;
  endfunction

  // A request with both enables set is a write; the slave never sees both.
  function automatic minibus_req_t write_wins(input minibus_req_t r);
    minibus_req_t o;
    o     = r;
    o.ren = r.ren & ~r.wen;
    return o;
  endfunction

endpackage

// File: rtl/rv32ima_pkg.sv
// Core-wide constants and the minibus arbiter state encoding.
package rv32ima_pkg;

  localparam int BIT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/minibus_watchdog.sv
// Cycle counter that flags an access stuck for TIMEOUT cycles (TIMEOUT >= 2).
module minibus_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int              CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  // Next count: clear wins, saturate at the limit.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (clear) begin
      wd_cnt_d = '0;
    end else if (en && (wd_cnt_q != LIMIT)) begin
      wd_cnt_d = wd_cnt_q + CW'(1);
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign expired = (wd_cnt_q == LIMIT);

endmodule

// File: rtl/minibus_arbiter.sv
// Round-robin two-master arbiter for the RAM minibus slave, with a forced
// idle bubble after every access and a watchdog on stuck accesses.
module minibus_arbiter
  import rv32ima_pkg::*;
  import minibus_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               nrst,
  input  minibus_req_t [1:0] m_req,
  output minibus_res_t [1:0] m_res,
  output minibus_req_t       s_req,
  output logic               s_sel,
  input  minibus_res_t       s_res,
  output logic               busy
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [1:0] active_s;
  logic       grant_idx_s;
  logic       wd_clear_s;
  logic       wd_expired_s;

  assign active_s   = {is_active(m_req[1]), is_active(m_req[0])};
  assign wd_clear_s = (state_q == IDLE);

  minibus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (wd_clear_s),
    .en      (busy),
    .expired (wd_expired_s)
  );

  // Next-state decision and slave/master muxing.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    s_req        = '0;
    s_sel        = 1'b0;
    busy         = (state_q != IDLE);
    grant_idx_s  = (state_q == GRANT1);
    for (int i = 0; i < 2; i++) begin
      m_res[i].ack   = 1'b0;
      m_res[i].err   = 1'b0;
      m_res[i].rdata = s_res.rdata;
    end

    case (state_q)
      IDLE: begin
        if (active_s == 2'b11) begin
          state_d      = last_grant_q ? GRANT0 : GRANT1;
          last_grant_d = ~last_grant_q;
        end else if (active_s[0]) begin
          state_d      = GRANT0;
          last_grant_d = 1'b0;
        end else if (active_s[1]) begin
          state_d      = GRANT1;
          last_grant_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        s_sel                  = 1'b1;
        s_req                  = write_wins(m_req[grant_idx_s]);
        m_res[grant_idx_s].ack = s_res.ack;
        m_res[grant_idx_s].err = s_res.err;
        // Any exit from a grant lands in IDLE, which is the mandatory bubble.
        if (s_res.ack || s_res.err) begin
          state_d = IDLE;
        end else if (wd_expired_s) begin
          m_res[grant_idx_s].err = 1'b1;
          s_req                  = '0;
          state_d                = IDLE;
        end else if (!active_s[grant_idx_s]) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant state and round-robin pointer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
